// File: rtl/audio_pkg.sv
// audio_pkg -- shared constants for the I2S audio transmit path.
//   SAMPLE_W    : PCM sample width
//   FRAME_SLOTS : BCLK periods per stereo frame
//   SLOT_W      : width of the slot counter
//   DIV_W       : width of the BCLK divider counter (CLK_DIV up to 255)
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);
  localparam int DIV_W       = 8;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div -- BCLK generator.
// The counter runs 0..CLK_DIV-1. At terminal count bclk toggles and the
// counter wraps. tick flags the terminal count while bclk is high, which
// is the clk edge at which bclk falls.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : run; low clears the counter and holds bclk at 0
//   tick     : falling-edge event (combinational, one clk wide)
//   bclk     : bit clock level (registered)
module clk_en_div
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic bclk
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic             term;

  assign term = (cnt == TERM);
  assign tick = en & term & bclk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx -- mono PCM to I2S serializer.
// One 16-bit sample is buffered in a holding register and sent as both the
// left and right word of a 32-slot frame. sdata lags lrck by one BCLK, so a
// new frame's first bit appears in slot 1; slot 0 still carries the previous
// frame's right-word LSB.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   enable       : serializer run; low idles bclk/lrck/sdata at 0
//   sample_in    : signed PCM sample
//   sample_valid : sample_in valid this cycle
//   sample_ready : holding register empty
//   bclk         : I2S bit clock
//   lrck         : word select, 0 = left, 1 = right
//   sdata        : serial data, MSB first
//   underrun     : one-clk pulse when a frame loads with no new sample
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun
);

  logic                  tick;
  logic                  load;
  logic                  accept;
  logic                  hold_full;
  logic [SLOT_W-1:0]     k;
  logic [SLOT_W-1:0]     k_next;
  logic [2*SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W-1:0]   hold_reg;
  logic [SAMPLE_W-1:0]   last_sample;
  logic [SAMPLE_W-1:0]   frame_sample;

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .tick (tick),
    .bclk (bclk)
  );

  // Frame load happens on the falling-edge event that leaves slot 0.
  assign load         = tick & (k == '0);
  assign k_next       = k + SLOT_W'(1);
  assign frame_sample = hold_full ? hold_reg : last_sample;

  // Handshake: a sample transfers on a rising clk edge where sample_valid and
  // sample_ready are both high; the source keeps sample_in stable until then.
  // Ready is the registered empty flag, forced low during a load cycle so the
  // holding register never takes a write while it is being drained.
  assign sample_ready = ~hold_full & ~load;
  assign accept       = sample_valid & sample_ready;

  // Slot counter, word select and serial data, all moved only by tick.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      k         <= '0;
      shift_reg <= '0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
    end else if (tick) begin
      k    <= k_next;
      lrck <= k_next[SLOT_W-1];
      if (load) begin
        shift_reg <= {frame_sample, frame_sample};
        sdata     <= frame_sample[SAMPLE_W-1];
      end else begin
        // sdata takes the bit that becomes the MSB after this shift.
        shift_reg <= shift_reg << 1;
        sdata     <= shift_reg[2*SAMPLE_W-2];
      end
    end
  end

  // Holding register, last-sample memory and underrun flag. These keep
  // running while enable is low so the source can prefill a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full   <= 1'b0;
      hold_reg    <= '0;
      last_sample <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= load & ~hold_full;
      if (load) begin
        last_sample <= frame_sample;
        hold_full   <= 1'b0;
      end else if (accept) begin
        hold_reg  <= sample_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx -- directed bench for audio_i2s_tx with CLK_DIV = 4.
// The stimulus process pushes {expected_underrun, sample} per frame into
// exp_q; the monitor rebuilds each frame from bclk/lrck/sdata and checks it.
module tb_audio_i2s_tx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        underrun;

  int checks = 0;
  int fails  = 0;

  logic [16:0] exp_q[$];

  audio_i2s_tx #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- compare helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Presents d with valid high until accepted; valid is left high.
  task automatic send(input logic [15:0] d, input logic und);
    int  n;
    logic r;
    n = 0;
    sample_valid = 1'b1;
    sample_in    = d;
    while (1) begin
      @(negedge clk);
      r = sample_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 2000) begin
        bound_fail("send_accept");
        break;
      end
    end
    exp_q.push_back({und, d});
  endtask

  task automatic wait_underrun(input string name);
    int n;
    n = 0;
    while (underrun !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 600) begin
        bound_fail(name);
        break;
      end
    end
  endtask

  task automatic wait_q_size(input int sz, input string name);
    int n;
    n = 0;
    while (exp_q.size() != sz) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 3000) begin
        bound_fail(name);
        break;
      end
    end
  endtask

  // Raise enable and count clks until sample_ready returns (frame load).
  task automatic enable_and_time_load(input string name);
    int n;
    n = 0;
    enable = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sample_ready !== 1'b1 && n < 100);
    chk(name, n, 8);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          mk;
  int          gap;
  int          hi;
  bit          have_fall;
  logic        prev_bclk;
  logic [31:0] frame_bits;
  logic [16:0] exp_e;

  always @(negedge clk) begin
    if (rst || !enable) begin
      mk        = 0;
      gap       = 0;
      hi        = 0;
      have_fall = 1'b0;
      prev_bclk = 1'b0;
    end else begin
      gap++;
      if (prev_bclk && !bclk) begin
        chk("bclk_high_clks", hi, 4);
        if (have_fall) chk("bclk_period_clks", gap, 8);
        have_fall = 1'b1;
        gap       = 0;
        hi        = 0;
        mk        = (mk + 1) % 32;
        chk("lrck_slot", 32'(lrck), 32'(mk >= 16));
        frame_bits[31 - ((mk + 31) % 32)] = sdata;
        if (mk == 1) begin
          if (exp_q.size() == 0) bound_fail("underrun_no_expected");
          else chk("underrun_at_load", 32'(underrun), 32'(exp_q[0][16]));
        end else begin
          chk("underrun_spurious", 32'(underrun), 32'd0);
        end
        if (mk == 0) begin
          if (exp_q.size() == 0) begin
            bound_fail("frame_no_expected");
          end else begin
            exp_e = exp_q.pop_front();
            chk("frame_word", frame_bits, {exp_e[15:0], exp_e[15:0]});
          end
        end
      end else begin
        chk("underrun_spurious", 32'(underrun), 32'd0);
      end
      if (bclk) hi++;
      prev_bclk = bclk;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    bound_fail("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic pb;

    rst          = 1'b1;
    enable       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrck", 32'(lrck), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Prefill A5C3 while idle; it is sent in frame 1, repeated in frame 2.
    send(16'hA5C3, 1'b0);
    sample_valid = 1'b0;
    chk("ready_after_accept", 32'(sample_ready), 32'd0);
    exp_q.push_back({1'b1, 16'hA5C3});
    enable_and_time_load("first_load_latency");

    // Frame 2 loads with nothing new.
    wait_underrun("wait_underrun_frame2");

    // Valid held high with changing data: one sample per frame, in order.
    send(16'h1357, 1'b0);
    send(16'h8001, 1'b0);
    send(16'h7FFE, 1'b0);
    send(16'hC0DE, 1'b0);
    sample_valid = 1'b0;

    // Buffer one more sample, then drop enable mid-frame.
    send(16'h5A5A, 1'b0);
    sample_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    enable = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      chk("idle_outputs", {28'd0, bclk, lrck, sdata, underrun}, 32'd0);
      chk("idle_ready_held", 32'(sample_ready), 32'd0);
      @(posedge clk);
      #1;
    end

    // Re-enable: the held sample starts a clean frame, the next underruns.
    exp_q.push_back({1'b0, 16'h5A5A});
    exp_q.push_back({1'b1, 16'h5A5A});
    enable_and_time_load("reenable_load_latency");
    wait_q_size(1, "wait_held_frame");
    wait_underrun("wait_underrun_reenable");

    // Buffer a sample, then reset at slot 20.
    send(16'h1234, 1'b0);
    sample_valid = 1'b0;
    n  = 0;
    pb = bclk;
    while (n < 19) begin
      @(negedge clk);
      if (pb && !bclk) n++;
      pb = bclk;
    end
    @(posedge clk);
    #1;
    chk("lrck_before_rst", 32'(lrck), 32'd1);
    chk("ready_before_rst", 32'(sample_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_bclk", 32'(bclk), 32'd0);
    chk("midrst_lrck", 32'(lrck), 32'd0);
    chk("midrst_sdata", 32'(sdata), 32'd0);
    chk("midrst_underrun", 32'(underrun), 32'd0);
    chk("midrst_ready", 32'(sample_ready), 32'd1);
    enable = 1'b0;
    rst    = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("final_ready", 32'(sample_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
